// File: rtl/gate_identifier.sv
// Two-input gate tester: sweeps {a,b} = 00..11 and samples the gate output to build a truth table.
// Then classifies the table into a gate code. Optional macro INPUT_SYNC_EN adds a two-flop synchronizer on dut_y.
module gate_identifier #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic [2:0] gate_code,
    output logic       valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

`ifdef INPUT_SYNC_EN
    // Two extra settle cycles cover the synchronizer delay; widen so 255+2 still fits.
    localparam int CNT_W = 9;
    localparam int LOAD  = SETTLE_CYCLES + 2;
`else
    localparam int CNT_W = 8;
    localparam int LOAD  = SETTLE_CYCLES;
`endif
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD);

    state_t           state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       truth_work;
    logic             y_smp;
    logic [3:0]       sample_vec;
    logic [2:0]       sample_code;

`ifdef INPUT_SYNC_EN
    logic y_meta, y_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_meta <= 1'b0;
            y_sync <= 1'b0;
        end else begin
            y_meta <= dut_y;
            y_sync <= y_meta;
        end
    end

    assign y_smp = y_sync;
`else
    assign y_smp = dut_y;
`endif

    function automatic logic [2:0] classify(input logic [3:0] t);
        logic [2:0] code;
        code = 3'd0;
        case (t)
            4'b1000: code = 3'd1;
            4'b1110: code = 3'd2;
            4'b0011: code = 3'd3;
            4'b0111: code = 3'd4;
            4'b0001: code = 3'd5;
            4'b0110: code = 3'd6;
            4'b1001: code = 3'd7;
            default: code = 3'd0;
        endcase
        return code;
    endfunction

    // Final vector is not stored; it is merged directly into the result.
    assign sample_vec  = {y_smp, truth_work};
    assign sample_code = classify(sample_vec);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_work
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    truth_work[gi] <= 1'b0;
                end else if (state == SAMPLE && idx == 2'(gi)) begin
                    truth_work[gi] <= y_smp;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= '0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            truth     <= 4'd0;
            gate_code <= 3'd0;
            valid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= 2'd0;
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (idx != 2'd3) begin
                        idx            <= idx + 2'd1;
                        {dut_a, dut_b} <= idx + 2'd1;
                        cnt            <= CNT_LOAD;
                        state          <= SETTLE;
                    end else begin
                        truth          <= sample_vec;
                        gate_code      <= sample_code;
                        valid          <= (sample_code != 3'd0);
                        {dut_a, dut_b} <= 2'b00;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        state          <= REPORT;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier: a modelled gate under test drives dut_y from dut_a/dut_b.
module tb_gate_identifier;

`ifdef INPUT_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int PER    = 2 + 2 + EXTRA;   // per-vector cycles, SETTLE_CYCLES=2
    localparam int N_DONE = 4 * PER + 1;
    localparam int PER0   = 0 + 2 + EXTRA;   // SETTLE_CYCLES=0 instance
    localparam int N_DONE0 = 4 * PER0 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dut_a, dut_b, dut_y;
    logic       busy, done, valid;
    logic [3:0] truth;
    logic [2:0] gate_code;

    logic       start0 = 1'b0;
    logic       a0, b0, y0;
    logic       busy0, done0, valid0;
    logic [3:0] truth0;
    logic [2:0] code0;

    int         gut_sel = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] prev_truth = 4'd0;

    always #5 clk = ~clk;

    gate_identifier #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
        .busy(busy), .done(done), .truth(truth),
        .gate_code(gate_code), .valid(valid)
    );

    gate_identifier #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .dut_a(a0), .dut_b(b0), .dut_y(y0),
        .busy(busy0), .done(done0), .truth(truth0),
        .gate_code(code0), .valid(valid0)
    );

    always_comb begin
        dut_y = 1'b0;
        case (gut_sel)
            0: dut_y = dut_a & dut_b;
            1: dut_y = dut_a | dut_b;
            2: dut_y = ~dut_a;
            3: dut_y = ~(dut_a & dut_b);
            4: dut_y = ~(dut_a | dut_b);
            5: dut_y = dut_a ^ dut_b;
            6: dut_y = ~(dut_a ^ dut_b);
            7: dut_y = 1'b1;
            default: dut_y = 1'b0;
        endcase
    end

    assign y0 = a0 ^ b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full sweep with the selected GUT; optional stray start pulse at edge restart_at.
    task automatic run_sweep(input int sel, input logic [3:0] exp_truth, input logic [2:0] exp_code,
                             input string tag, input int restart_at);
        int done_edge;
        done_edge = 0;
        gut_sel = sel;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy_e1"}, {7'd0, busy}, 8'd1);
        chk({tag, " ab_e1"}, {6'd0, dut_a, dut_b}, 8'd0);
        for (int e = 2; e <= N_DONE + 8; e++) begin
            @(posedge clk);
            #1;
            start = (e == restart_at) ? 1'b1 : 1'b0;
            if (e == 1 + PER || e == 1 + 2 * PER || e == 1 + 3 * PER)
                chk({tag, " ab_step"}, {6'd0, dut_a, dut_b}, 8'((e - 1) / PER));
            if (e == N_DONE - 1)
                chk({tag, " truth_hold"}, {4'd0, truth}, {4'd0, prev_truth});
            if (done === 1'b1) begin
                done_edge = e;
                break;
            end
        end
        start = 1'b0;
        chk({tag, " done_edge"}, 8'(done_edge), 8'(N_DONE));
        chk({tag, " truth"}, {4'd0, truth}, {4'd0, exp_truth});
        chk({tag, " code"}, {5'd0, gate_code}, {5'd0, exp_code});
        chk({tag, " valid"}, {7'd0, valid}, {7'd0, exp_code != 3'd0});
        chk({tag, " busy_done"}, {7'd0, busy}, 8'd0);
        chk({tag, " ab_end"}, {6'd0, dut_a, dut_b}, 8'd0);
        $display("sweep %s: truth=%b code=%0d valid=%0d done_edge=%0d", tag, truth, gate_code, valid, done_edge);
        prev_truth = exp_truth;
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, {7'd0, done}, 8'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int seen;
        #1;
        chk("reset busy", {7'd0, busy}, 8'd0);
        chk("reset out", {truth, 1'b0, gate_code}, 8'd0);
        chk("reset ab", {5'd0, valid, dut_a, dut_b}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_sweep(0, 4'b1000, 3'd1, "AND", 0);
        run_sweep(1, 4'b1110, 3'd2, "OR", 0);
        run_sweep(2, 4'b0011, 3'd3, "NOTA", 0);
        run_sweep(3, 4'b0111, 3'd4, "NAND", 0);
        run_sweep(4, 4'b0001, 3'd5, "NOR", 0);
        run_sweep(5, 4'b0110, 3'd6, "XOR", 0);
        run_sweep(6, 4'b1001, 3'd7, "XNOR", 0);
        run_sweep(7, 4'b1111, 3'd0, "ONE", 0);
        run_sweep(8, 4'b0000, 3'd0, "ZERO", 0);
        run_sweep(6, 4'b1001, 3'd7, "XNOR2", 0);
        run_sweep(0, 4'b1000, 3'd1, "AND_restart", 5);

        // Asynchronous reset between edges mid-sweep.
        gut_sel = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst busy", {7'd0, busy}, 8'd0);
        chk("rst done", {7'd0, done}, 8'd0);
        chk("rst truth", {4'd0, truth}, 8'd0);
        chk("rst code", {4'd0, valid, gate_code}, 8'd0);
        chk("rst ab", {6'd0, dut_a, dut_b}, 8'd0);
        $display("async reset mid-sweep: busy=%0d truth=%b code=%0d", busy, truth, gate_code);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < N_DONE + 4; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        chk("rst no_done", 8'(seen), 8'd0);
        prev_truth = 4'd0;
        run_sweep(0, 4'b1000, 3'd1, "AND_after_rst", 0);

        // SETTLE_CYCLES=0 instance with an XOR gate.
        seen = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        for (int e = 2; e <= N_DONE0 + 8; e++) begin
            @(posedge clk);
            #1;
            if (done0 === 1'b1) begin
                seen = e;
                break;
            end
        end
        chk("S0 done_edge", 8'(seen), 8'(N_DONE0));
        chk("S0 truth", {4'd0, truth0}, 8'b0110);
        chk("S0 code", {4'd0, valid0, code0}, {4'd0, 1'b1, 3'd6});
        chk("S0 busy", {7'd0, busy0}, 8'd0);
        $display("sweep S0_XOR: truth=%b code=%0d valid=%0d done_edge=%0d", truth0, code0, valid0, seen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_identifier.md
Name: gate_identifier

Overview:
- Sequential tester for the two-input logic gates in the digital-electronics library: drives the stimulus side of a gate under test (GUT) and reads back its single output.
- Sweeps all four {a,b} input combinations, waits a settle time on each, samples the GUT output, builds a 4-bit truth table and classifies it into a gate type.
- Sits beside any gate instance on the bench or in lab top-levels, and closes the loop on the combinational gate set.

Parameters:
- SETTLE_CYCLES, 2, number of extra cycles each vector is held before sampling (0..255; counter width 8).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; accepted only in IDLE
- dut_a  output  1  GUT input a
- dut_b  output  1  GUT input b
- dut_y  input  1  GUT output
- busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE)
- done  output  1  one-cycle pulse when the result is updated
- truth  output  4  truth[i] = GUT output for {a,b} = i (i = 2*a + b)
- gate_code  output  3  classified gate type
- valid  output  1  high when gate_code != 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. While rst is high, all registers clear: state=IDLE, dut_a=dut_b=0, busy=0, done=0, truth=0, gate_code=0, valid=0, idx=0, cnt=0.
- States:
  - IDLE: on start=1 at a rising edge: idx<=0, {dut_a,dut_b}<=00, cnt<=SETTLE_CYCLES, go to SETTLE.
  - SETTLE: if cnt==0, go to SAMPLE; else cnt<=cnt-1. Stays SETTLE_CYCLES+1 cycles.
  - SAMPLE: at the edge, truth_work[idx]<=dut_y.
    - If idx<3: idx<=idx+1, {dut_a,dut_b}<=idx+1, cnt<=SETTLE_CYCLES, go to SETTLE.
    - If idx==3: update truth, gate_code and valid from {dut_y, truth_work[2:0]}, drive {dut_a,dut_b}<=00, go to REPORT.
  - REPORT: done=1 for exactly this cycle; busy=0; go to IDLE unconditionally.
- Latency: per vector SETTLE_CYCLES+2 cycles. done is high in the cycle following the 4*(SETTLE_CYCLES+2)+1-th rising edge counted from the edge that accepted start. With the default of 2, that is edge 17.
- Outputs: busy, done, truth, gate_code and valid are all registered. truth, gate_code and valid change only at the edge entering REPORT and hold until the next sweep completes.
- Classification (truth -> gate_code):
  - 1000 -> 1 AND
  - 1110 -> 2 OR
  - 0011 -> 3 NOT (~a)
  - 0111 -> 4 NAND
  - 0001 -> 5 NOR
  - 0110 -> 6 XOR
  - 1001 -> 7 XNOR
  - anything else -> 0, valid=0
- Boundary conditions:
  - start while busy or in REPORT: ignored, with no effect on the sweep.
  - start held high: a new sweep begins on the first IDLE cycle after REPORT.
  - SETTLE_CYCLES=0: one SETTLE cycle per vector.
  - rst asserted mid-sweep: immediate abort to reset values, and the previous result is lost.
  - dut_y changing during SETTLE: not observed. Only the SAMPLE-edge value counts.

Optional Feature:
- Macro INPUT_SYNC_EN.
- Defined: dut_y passes through a two-flop synchronizer before sampling, and the settle counter is loaded with SETTLE_CYCLES+2. Per-vector time becomes SETTLE_CYCLES+4 and done latency becomes 4*(SETTLE_CYCLES+4)+1 edges. The synchronizer flops clear on rst.
- Undefined: dut_y is sampled directly with the latency given above, and no synchronizer flops exist.

Test Plan:
- Loop dut_y = dut_a & dut_b, SETTLE_CYCLES=2, pulse start -> done on the 17th edge after start, truth=1000, gate_code=1, valid=1, busy low in the done cycle.
- Run each of OR, NOT(a), NAND, NOR, XOR and XNOR in turn as the GUT -> truth 1110/0011/0111/0001/0110/1001, gate_code 2..7, valid=1. Check dut_a/dut_b step through 00, 01, 10, 11 and return to 00.
- Tie dut_y=1 -> truth=1111, gate_code=0, valid=0. Tie dut_y=0 -> truth=0000, gate_code=0.
- Pulse start again at cycle 5 of an AND sweep -> ignored; a single done on edge 17; the result from the prior sweep holds until then.
- Assert rst asynchronously between clock edges at cycle 9 of a sweep -> all outputs 0 immediately, no done pulse; a fresh start then completes normally.
- With SETTLE_CYCLES=0, and with INPUT_SYNC_EN defined and SETTLE_CYCLES=2 -> done on edge 9 and edge 25 respectively; the XOR GUT yields gate_code=6 in both.
